// File: rtl/uart_tx.sv
// uart_tx: UART transmit serializer fed by a first-word-fall-through TX FIFO.
// Frames are LSB first with one start bit and StopTicks/16 stop bits, timed by a
// shared 16x baud tick.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit between
// the last data bit and the stop period.
//
// state  | meaning
// IDLE   | line high; pop and launch when the FIFO has a word
// START  | start bit (low) for 16 ticks
// DATA   | data bits, LSB first, 16 ticks each
// PARITY | even parity bit for 16 ticks (UART_TX_PARITY_EN only)
// STOP   | line high for StopTicks ticks, then tx_done_o pulse
module uart_tx #(
  parameter int DataBits  = 8,
  parameter int StopTicks = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                s_tick_i,
  input  logic                tx_empty_i,
  input  logic [DataBits-1:0] tx_data_i,
  output logic                tx_rd_o,
  output logic                tx_o,
  output logic                tx_busy_o,
  output logic                tx_done_o
);

  localparam logic [5:0] TickLast = 6'd15;
  localparam logic [5:0] StopLast = 6'(StopTicks - 1);
  localparam logic [2:0] BitLast  = 3'(DataBits - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } state_t;
`endif

  state_t                state;
  logic [5:0]            tick_cnt;
  logic [2:0]            bit_cnt;
  logic [DataBits-1:0]   shreg;
  logic                  launch;
`ifdef UART_TX_PARITY_EN
  logic                  parity;
`endif

  // Launch only from IDLE with a word available, and never in the cycle that
  // tx_done_o is high, so IDLE lasts at least one cycle between frames.
  // Held low during reset so the FIFO is not popped while the block is held.
  assign launch    = rst_ni && (state == IDLE) && !tx_empty_i && !tx_done_o;
  assign tx_rd_o   = launch;
  assign tx_busy_o = (state != IDLE);

  // Frame sequencer with registered line and done outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      tick_cnt  <= 6'd0;
      bit_cnt   <= 3'd0;
      shreg     <= '0;
      tx_o      <= 1'b1;
      tx_done_o <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      tx_done_o <= 1'b0;
      case (state)
        IDLE: begin
          tx_o <= 1'b1;
          if (launch) begin
            shreg    <= tx_data_i;
            tick_cnt <= 6'd0;
            tx_o     <= 1'b0;
            state    <= START;
`ifdef UART_TX_PARITY_EN
            parity   <= ^tx_data_i;
`endif
          end
        end

        START: begin
          if (s_tick_i) begin
            if (tick_cnt == TickLast) begin
              tick_cnt <= 6'd0;
              bit_cnt  <= 3'd0;
              tx_o     <= shreg[0];
              state    <= DATA;
            end else begin
              tick_cnt <= tick_cnt + 6'd1;
            end
          end
        end

        DATA: begin
          if (s_tick_i) begin
            if (tick_cnt == TickLast) begin
              tick_cnt <= 6'd0;
              shreg    <= shreg >> 1;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == BitLast) begin
`ifdef UART_TX_PARITY_EN
                tx_o  <= parity;
                state <= PARITY;
`else
                tx_o  <= 1'b1;
                state <= STOP;
`endif
              end else begin
                // Line shows the bit that becomes shreg[0] after the shift.
                tx_o <= shreg[1];
              end
            end else begin
              tick_cnt <= tick_cnt + 6'd1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (s_tick_i) begin
            if (tick_cnt == TickLast) begin
              tick_cnt <= 6'd0;
              tx_o     <= 1'b1;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 6'd1;
            end
          end
        end
`endif

        STOP: begin
          tx_o <= 1'b1;
          if (s_tick_i) begin
            if (tick_cnt == StopLast) begin
              tick_cnt  <= 6'd0;
              tx_done_o <= 1'b1;
              state     <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 6'd1;
            end
          end
        end

        default: begin
          tx_o     <= 1'b1;
          tick_cnt <= 6'd0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven frames plus hand-written corner sequences, checked
// by a serial-line decoder against a scoreboard of pushed words.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int Par = 16;
`else
  localparam int Par = 0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick  = 1'b0;
  logic       sel   = 1'b0;
  logic       empty_m = 1'b1;
  logic [7:0] data_m  = 8'h00;

  logic empty_a, empty_b;
  logic rd_a, tx_a, busy_a, done_a;
  logic rd_b, tx_b, busy_b, done_b;
  logic rd, tx, busy, done;

  assign empty_a = sel ? 1'b1 : empty_m;
  assign empty_b = sel ? empty_m : 1'b1;
  assign rd   = sel ? rd_b   : rd_a;
  assign tx   = sel ? tx_b   : tx_a;
  assign busy = sel ? busy_b : busy_a;
  assign done = sel ? done_b : done_a;

  uart_tx #(.DataBits(8), .StopTicks(16)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .s_tick_i(tick), .tx_empty_i(empty_a),
    .tx_data_i(data_m), .tx_rd_o(rd_a), .tx_o(tx_a), .tx_busy_o(busy_a),
    .tx_done_o(done_a)
  );

  uart_tx #(.DataBits(8), .StopTicks(32)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .s_tick_i(tick), .tx_empty_i(empty_b),
    .tx_data_i(data_m), .tx_rd_o(rd_b), .tx_o(tx_b), .tx_busy_o(busy_b),
    .tx_done_o(done_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int   period   = 4;
  int   tick_ctr = 0;
  int   cyc      = 0;
  int   pops     = 0;
  bit   pop_now  = 0;
  bit   b2b_mode = 0;
  int   last_done_cyc = -10;

  bit         mon_active = 0;
  int         tcount     = 0;
  logic [7:0] word       = 8'h00;
  logic       par_bit    = 1'b0;
  logic       prev_tx    = 1'b1;
  bit         done_due   = 0;
  bit         meas_on    = 0;
  int         meas       = 0;
  int         last_meas  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic flag_fail(input string name, input int act, input int exp);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int frame_ticks();
    return 16 + 16 * 8 + (sel ? 32 : 16) + Par;
  endfunction

  task automatic drive_fifo();
    empty_m = (fifo_q.size() == 0);
    data_m  = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
  endtask

  task automatic push_word(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    drive_fifo();
  endtask

  // Sampled at the falling edge: outputs settled, inputs stable.
  task automatic mon_sample();
    int i;
    logic [7:0] e;
    cyc++;
    if (done_due || done) check("tx_done", int'(done), int'(done_due));
    done_due = 0;
    if (done) last_done_cyc = cyc;
    if (meas_on && done) begin
      last_meas = meas;
      meas_on   = 0;
    end else if (meas_on && tick) begin
      meas++;
    end
    if (rd) begin
      if (fifo_q.size() == 0) flag_fail("pop_while_empty", 1, 0);
      pops++;
      pop_now = 1;
      meas    = 0;
      meas_on = 1;
      if (b2b_mode && pops > 1) check("b2b_pop_cycle", cyc, last_done_cyc + 1);
    end
    if (mon_active && !busy) flag_fail("busy_in_frame", 0, 1);
    if (!mon_active && tx === 1'b0) begin
      mon_active = 1;
      tcount     = 0;
      word       = 8'h00;
      prev_tx    = 1'b0;
    end
    if (mon_active) begin
      if (tx !== prev_tx && (tcount % 16) != 0) flag_fail("edge_tick_position", tcount % 16, 0);
      prev_tx = tx;
      if (tick) begin
        tcount++;
        if ((tcount % 16) == 8) begin
          i = tcount / 16;
          if (i == 0) check("start_bit", int'(tx), 0);
          else if (i <= 8) word[i-1] = tx;
          else if (Par != 0 && i == 9) par_bit = tx;
          else check("stop_bit", int'(tx), 1);
        end
        if (tcount == frame_ticks()) begin
          mon_active = 0;
          done_due   = 1;
          if (exp_q.size() == 0) begin
            flag_fail("unexpected_frame", int'(word), -1);
          end else begin
            e = exp_q.pop_front();
            check("data_word", int'(word), int'(e));
`ifdef UART_TX_PARITY_EN
            check("parity_bit", int'(par_bit), int'(^e));
`endif
          end
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    mon_sample();
    @(posedge clk);
    #1;
    if (pop_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
    pop_now  = 0;
    tick     = (tick_ctr == 0);
    tick_ctr = (tick_ctr + 1) % period;
    drive_fifo();
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      cycle();
      ok = (fifo_q.size() == 0) && (exp_q.size() == 0) && !mon_active &&
           !done_due && !busy && !done;
    end
    if (!ok) flag_fail("timeout_wait_idle", budget, 0);
    cycle();
  endtask

  typedef struct {
    logic       s;
    int         per;
    logic [7:0] w;
    int         ticks;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int bad;
    vecs[0] = '{1'b0, 4, 8'hA5, 160 + Par};
    vecs[1] = '{1'b0, 1, 8'h81, 160 + Par};
    vecs[2] = '{1'b0, 3, 8'h3C, 160 + Par};
    vecs[3] = '{1'b1, 4, 8'h3C, 176 + Par};
    vecs[4] = '{1'b1, 2, 8'h96, 176 + Par};
    vecs[5] = '{1'b0, 2, 8'h07, 160 + Par};
    vecs[6] = '{1'b0, 5, 8'h03, 160 + Par};

    // Reset with FIFO empty, then a long idle stretch.
    #1 rst_n = 1'b0;
    drive_fifo();
    repeat (3) cycle();
    check("reset_tx", int'(tx), 1);
    check("reset_rd", int'(rd), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst_n = 1'b1;
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      cycle();
      if (tx !== 1'b1 || rd !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("idle_bad_cycles", bad, 0);

    // Single frames from the vector table.
    for (int v = 0; v < 7; v++) begin
      sel      = vecs[v].s;
      period   = vecs[v].per;
      tick_ctr = 0;
      pops     = 0;
      last_meas = 0;
      push_word(vecs[v].w);
      wait_idle(4000);
      check("vec_pops", pops, 1);
      check("vec_frame_ticks", last_meas, vecs[v].ticks);
    end

    // Back-to-back frames.
    sel = 1'b0; period = 2; tick_ctr = 0; pops = 0; b2b_mode = 1;
    push_word(8'h00);
    push_word(8'hFF);
    push_word(8'h55);
    wait_idle(3000);
    b2b_mode = 0;
    check("b2b_pops", pops, 3);
    check("b2b_fifo_empty", int'(empty_m), 1);

    // Reset during data bit 3 of 0xF0; the following word must go out intact.
    sel = 1'b0; period = 4; tick_ctr = 0; pops = 0;
    push_word(8'hF0);
    push_word(8'h3C);
    bad = 1;
    for (int n = 0; n < 2000 && bad == 1; n++) begin
      cycle();
      if (mon_active && tcount >= 16 * 4 + 8) bad = 0;
    end
    if (bad == 1) flag_fail("timeout_reach_bit3", 2000, 0);
    check("pre_reset_line_low", int'(tx), 0);
    rst_n = 1'b0;
    #1;
    check("async_reset_tx", int'(tx), 1);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_rd", int'(rd), 0);
    mon_active = 0;
    done_due   = 0;
    meas_on    = 0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    pops = 0;
    repeat (3) cycle();
    rst_n = 1'b1;
    wait_idle(4000);
    check("post_reset_pops", pops, 1);
    check("post_reset_frame_ticks", last_meas, 160 + Par);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmit serializer. It sits directly downstream of the TX FIFO and pops one word whenever the FIFO is non-empty and the serializer is idle. Each word is sent as an LSB-first asynchronous frame on tx_o, timed by a shared 16x-oversampling baud tick. The FIFO read port is first-word-fall-through: read data is valid combinationally whenever the FIFO is not empty.

Parameters:
DataBits, 8, number of data bits per frame (5..8)
StopTicks, 16, baud ticks spent in the stop state (16/24/32 = 1/1.5/2 stop bits); legal range 16..63

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous, active-low reset
s_tick_i  input  1  baud tick, one clk_i cycle wide, 16 per bit period
tx_empty_i  input  1  FIFO empty flag
tx_data_i  input  DataBits  FIFO read data (valid when tx_empty_i=0)
tx_rd_o  output  1  FIFO pop strobe, one cycle
tx_o  output  1  serial line, idle high
tx_busy_o  output  1  high in every state except IDLE
tx_done_o  output  1  one-cycle pulse at end of stop period

Behaviour:
- Reset (rst_ni=0, asynchronous): state IDLE; tx_o=1; tx_rd_o=0; tx_busy_o=0; tx_done_o=0; tick counter, bit counter and shift register cleared. All outputs are registered except tx_rd_o and tx_busy_o, which are decoded from the state.
- States: IDLE, START, DATA, STOP, plus PARITY when the optional feature is enabled.
- IDLE: tx_o=1. If tx_empty_i=0, in the same cycle:
  - tx_rd_o=1;
  - load tx_data_i into the shift register;
  - clear the tick counter;
  - next state START.
  tx_rd_o is asserted only in this IDLE-and-not-empty cycle, so a single pop occurs per frame and the FIFO is never popped while empty.
- START: tx_o=0. Count s_tick_i. On the tick where the counter equals 15: clear the counter, clear the bit counter, go to DATA.
- DATA: tx_o = shift register bit 0. On the 16th tick:
  - shift right;
  - clear the tick counter;
  - increment the bit counter.
  After bit DataBits-1 completes, go to STOP, or to PARITY if enabled.
- STOP: tx_o=1. On the tick where the counter equals StopTicks-1: tx_done_o=1 for one cycle, next state IDLE.
- Ticks are counted only while s_tick_i=1; cycles without a tick hold all state. The tick counter is 6 bits.
- Back-to-back frames: IDLE lasts at least one clk_i cycle between frames. With the FIFO still non-empty, the next pop occurs in the cycle after tx_done_o.
- Frame length (no parity) = 16 + 16*DataBits + StopTicks ticks, plus one launch cycle.
- Changes on tx_data_i or tx_empty_i outside IDLE are ignored.
- Reset mid-frame: the line returns high immediately and the word already popped is discarded.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP, lasting 16 ticks. tx_o = even parity, i.e. the XOR of the DataBits data bits captured at launch.
- Not defined: DATA goes directly to STOP. No parity logic or parity register is synthesized.

Test Plan:
- Reset then idle: rst_ni pulsed low with FIFO empty -> tx_o=1, tx_rd_o=0, tx_busy_o=0 for 1000 cycles.
- Single word, tick every 4 clocks: FIFO holds 0xA5 -> exactly one tx_rd_o pulse; line shows 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1. Each bit is 64 clocks wide; tx_done_o fires 160 ticks after the launch cycle.
- Back-to-back: FIFO holds 0x00, 0xFF, 0x55 -> three pops, each in the cycle after the previous tx_done_o. Decoded bytes are correct and FIFO empty is reached after the third pop.
- StopTicks=32: send 0x3C -> stop level held 32 ticks; frame is 176 ticks.
- Reset mid-frame: assert rst_ni during DATA bit 3 of 0xF0 -> tx_o=1 asynchronously, state IDLE. After release, the next FIFO word is sent as a complete, correct frame.
- UART_TX_PARITY_EN defined: send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frame is 176 ticks.
